// File: rtl/fixed_point_divider_if.sv
// Handshake and operand bundle for fixed_point_divider.
// The requester drives the operands and trigger. The divider returns ready/done, the result flags and its FSM state.
interface fixed_point_divider_if #(
    parameter int C_WIDTH = 32
);
    logic [C_WIDTH-1:0] a;
    logic [C_WIDTH-1:0] b;
    logic               signed_cal;
    logic               trigger;
    logic               ready;
    logic               done;
    logic [C_WIDTH-1:0] y;
    logic               overflow;
    logic               div_zero;
    logic [1:0]         dbg_state;

    // Handshake: trigger is taken only on an edge where ready=1, and operands need only be stable on that edge.
    // done pulses for one cycle with ready=0. y/overflow/div_zero hold until the next done.
    modport master (
        output a, b, signed_cal, trigger,
        input  ready, done, y, overflow, div_zero, dbg_state
    );
    modport slave (
        input  a, b, signed_cal, trigger,
        output ready, done, y, overflow, div_zero, dbg_state
    );
endinterface

// File: rtl/fixed_point_divider.sv
// Restoring fixed-point divider that produces one quotient bit per clock, working on operand magnitudes.
// With `DIVIDER_SATURATE_EN defined, y saturates on overflow; otherwise y wraps.
module fixed_point_divider #(
    parameter int C_WIDTH     = 32,
    parameter int FIXED_POINT = 8,
    parameter int USE_CLA     = 1
) (
    input  logic                 ctl_clk,
    input  logic                 reset,
    fixed_point_divider_if.slave bus
);
    localparam int N  = C_WIDTH + FIXED_POINT;
    localparam int CW = $clog2(N);
    localparam int RW = C_WIDTH + 2;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [N-1:0]       shift_q;
    logic [C_WIDTH:0]   rem_q;
    logic [C_WIDTH-1:0] bmag_q;
    logic               neg_q;
    logic               sgn_q;
    logic               ready_q;
    logic               done_q;
    logic               ovf_q;
    logic               dz_q;
    logic [C_WIDTH-1:0] y_q;

    logic [C_WIDTH-1:0] a_mag_d;
    logic [C_WIDTH-1:0] b_mag_d;
    logic               neg_d;
    logic [RW-1:0]      trial_x;
    logic [RW-1:0]      trial_y;
    logic [RW-1:0]      trial_d;
    logic               q_bit;
    logic [C_WIDTH:0]   rem_d;
    logic [N-1:0]       quot_d;
    logic               ovf_d;
    logic [C_WIDTH-1:0] y_wrap_d;
    logic [C_WIDTH-1:0] y_d;

    function automatic logic [C_WIDTH-1:0] sat_value(input logic sgn, input logic neg);
        logic [C_WIDTH-1:0] v;
        if (!sgn)     v = '1;
        else if (neg) v = {1'b1, {(C_WIDTH-1){1'b0}}};
        else          v = {1'b0, {(C_WIDTH-1){1'b1}}};
        return v;
    endfunction

    assign a_mag_d = (bus.signed_cal && bus.a[C_WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag_d = (bus.signed_cal && bus.b[C_WIDTH-1]) ? -bus.b : bus.b;
    assign neg_d   = bus.signed_cal & (bus.a[C_WIDTH-1] ^ bus.b[C_WIDTH-1]);

    // The remainder stays below |b|, so the shifted remainder fits in C_WIDTH+1 bits. The top bit of the difference is the borrow.
    assign trial_x = {rem_q, shift_q[N-1]};
    assign trial_y = {2'b00, bmag_q};

    generate
        if (USE_CLA != 0) begin : g_cla
            assign trial_d = trial_x - trial_y;
        end else begin : g_rca
            logic [RW-1:0] brw;
            assign brw[0] = 1'b0;
            for (genvar i = 0; i < RW; i++) begin : g_bit
                assign trial_d[i] = trial_x[i] ^ trial_y[i] ^ brw[i];
                if (i < RW - 1) begin : g_brw
                    assign brw[i+1] = (~trial_x[i] & trial_y[i]) |
                                      (~(trial_x[i] ^ trial_y[i]) & brw[i]);
                end
            end
        end
    endgenerate

    assign q_bit  = ~trial_d[RW-1];
    assign rem_d  = q_bit ? trial_d[C_WIDTH:0] : trial_x[C_WIDTH:0];
    assign quot_d = {shift_q[N-2:0], q_bit};

    // A negative result may reach magnitude 2^(C_WIDTH-1), which is the most negative code.
    always_comb begin
        ovf_d = 1'b0;
        if (!sgn_q)
            ovf_d = |quot_d[N-1:C_WIDTH];
        else if (neg_q)
            ovf_d = (|quot_d[N-1:C_WIDTH-1]) && (quot_d != (N'(1) << (C_WIDTH-1)));
        else
            ovf_d = |quot_d[N-1:C_WIDTH-1];
    end

    assign y_wrap_d = neg_q ? -quot_d[C_WIDTH-1:0] : quot_d[C_WIDTH-1:0];
`ifdef DIVIDER_SATURATE_EN
    assign y_d = ovf_d ? sat_value(sgn_q, neg_q) : y_wrap_d;
`else
    assign y_d = y_wrap_d;
`endif

    always_ff @(posedge ctl_clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            rem_q   <= '0;
            bmag_q  <= '0;
            neg_q   <= 1'b0;
            sgn_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            y_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.trigger) begin
                        ready_q <= 1'b0;
                        bmag_q  <= b_mag_d;
                        neg_q   <= neg_d;
                        sgn_q   <= bus.signed_cal;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        shift_q <= {a_mag_d, {FIXED_POINT{1'b0}}};
                        if (b_mag_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            dz_q    <= 1'b1;
                            ovf_q   <= 1'b0;
                            y_q     <= sat_value(bus.signed_cal, neg_d);
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q   <= rem_d;
                    shift_q <= quot_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        dz_q    <= 1'b0;
                        ovf_q   <= ovf_d;
                        y_q     <= y_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.y         = y_q;
    assign bus.overflow  = ovf_q;
    assign bus.div_zero  = dz_q;
    assign bus.dbg_state = state_q;
endmodule

// File: doc/fixed_point_divider.md
# fixed_point_divider

Multi-cycle sequential divider, the inverse of the synthesizer's fixed-point multiplier. It computes y = a / b on C_WIDTH-bit fixed-point operands with FIXED_POINT fractional bits. It uses restoring division at one quotient bit per clock, and the same trigger/ready/done handshake as the multi-cycle multipliers. Signed operands are handled by magnitude conversion before the division and sign restoration after it, so it drops into the same datapath slots as the multiplier.

## Interface
- C_WIDTH, 32, operand/result width in bits.
- FIXED_POINT, 8, number of fractional bits in a, b and y.
- USE_CLA, 1, 1 selects carry-lookahead subtractor, 0 selects ripple-carry.

Ports:
- ctl_clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- a  input  C_WIDTH  dividend.
- b  input  C_WIDTH  divisor.
- signed_cal  input  1  1 = two's-complement operands/result, 0 = unsigned.
- trigger  input  1  start request; sampled only while ready=1.
- ready  output  1  idle, accepting trigger.
- done  output  1  one-cycle pulse; y/overflow/div_zero are valid from this cycle onward.
- y  output  C_WIDTH  quotient, fixed-point with FIXED_POINT fractional bits.
- overflow  output  1  quotient magnitude did not fit.
- div_zero  output  1  b was zero.

## Operation
- States: IDLE, CALC, DONE.
- Reset (asynchronous, reset=0):
  - state=IDLE; counter=0.
  - Outputs: ready=1, done=0, y=0, overflow=0, div_zero=0.
  - Applies immediately mid-operation; the in-flight result is discarded.
- IDLE, trigger=1 (edge E0):
  - Latch |a|, |b| and result sign = (a[MSB]^b[MSB])&signed_cal; magnitudes only when signed_cal=1.
  - Clear remainder; ready falls.
  - If |b|==0: go to DONE with div_zero=1, overflow=0 and y saturated:
    - unsigned: all ones;
    - signed, a>=0: 0x7FF..F;
    - signed, a<0: 0x800..0.
  - Otherwise go to CALC.
- CALC:
  - Shift register holds |a| extended to C_WIDTH+FIXED_POINT bits (|a| << FIXED_POINT).
  - Each edge: remainder (C_WIDTH+1 bits) = {remainder, next dividend bit}; trial subtract |b|; if non-negative keep the difference and shift in quotient bit 1, else restore and shift in 0.
  - N = C_WIDTH+FIXED_POINT iterations, counted 0..N-1.
  - After the last iteration, go to DONE.
- Entering DONE:
  - Evaluate the raw quotient Q (N bits).
  - overflow=1 if Q ≥ 2^C_WIDTH (unsigned), Q > 2^(C_WIDTH-1)-1 (signed positive), or Q > 2^(C_WIDTH-1) (signed negative).
  - y = sign-restored Q[C_WIDTH-1:0] (see Configuration); register y, overflow and div_zero.
- DONE: done=1 for exactly one cycle, then IDLE.
- Remainder is discarded; the quotient truncates toward zero in magnitude.
- trigger while ready=0 is ignored and never queued.
- y, overflow and div_zero hold their values until the next DONE entry or reset.

## Timing
- Normal latency:
  - trigger sampled at E0; CALC edges E1..EN; y registered at EN.
  - done high during the cycle after EN; ready high again after EN+1.
  - C_WIDTH=32, FIXED_POINT=8: done is 40 cycles after the trigger edge.
- Divide-by-zero: done high in the cycle after E0.
- ready and done are never high simultaneously.
- Minimum trigger-to-trigger spacing: N+2 cycles (normal), 2 cycles (b=0).
- Combinational paths from inputs to outputs: none. Operands only need to be stable at E0.

## Configuration
- DIVIDER_SATURATE_EN
  - Defined: on overflow, y is the saturated value (unsigned all ones; signed 0x7FF..F positive, 0x800..0 negative).
  - Undefined: on overflow, y is the sign-restored truncated Q[C_WIDTH-1:0].
  - The overflow flag behaves identically either way.
  - Divide-by-zero saturation is unconditional.

## Test plan
All scenarios use C_WIDTH=32, FIXED_POINT=8.
- Unsigned 1.5/0.5: a=0x180, b=0x080, signed_cal=0 -> done 40 cycles after trigger, y=0x300, overflow=0, div_zero=0.
- Signed -3.0/2.0: a=0xFFFFFD00, b=0x200, signed_cal=1 -> y=0xFFFFFE80, overflow=0.
- Divide by zero: a=0x100, b=0, signed_cal=1 -> done in cycle after trigger, div_zero=1, y=0x7FFFFFFF.
- Overflow: a=0x7FFFFFFF, b=0x1, signed_cal=1 -> overflow=1; y=0x7FFFFFFF with DIVIDER_SATURATE_EN, y=0xFFFFFF00 without.
- Busy trigger: second trigger with a=0x200 at cycle 10 of a 0x180/0x080 divide -> ignored, y=0x300, exactly one done pulse.
- Reset mid-CALC: reset=0 at cycle 20 -> immediately ready=1, done=0, y=0; a new trigger after release completes normally in 40 cycles.
